// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// Also holds a small address alignment helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between fetch and load/store.
// Data wins unless fetch has lost STARVE_LIMIT contended rounds in a row.
module arb_pick #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       i_if_req,
  input  logic       i_ls_req,
  input  logic [3:0] i_starve_cnt,
  output logic       o_grant_if,
  output logic       o_grant_ls,
  output logic       o_contend
);

  logic w_starved;

  assign w_starved  = (i_starve_cnt == 4'(STARVE_LIMIT));
  assign o_contend  = i_if_req & i_ls_req;
  assign o_grant_ls = i_ls_req & ~(i_if_req & w_starved);
  assign o_grant_if = i_if_req & ~o_grant_ls;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one handshaked backing memory port between fetch and load/store,
// one outstanding transaction at a time, with bounded fetch starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_ls_req,
  input  logic        i_ls_wen,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_mask,
  output logic        o_ls_ready,
  output logic        o_ls_valid,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_err,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic [3:0]  r_starve_cnt;

  logic        w_grant_if;
  logic        w_grant_ls;
  logic        w_contend;
  logic        w_idle;
  logic        w_accept;
  logic [31:0] w_sel_addr;
  logic        w_resp;
  logic        w_err;
  logic [31:0] w_rdata;

  arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_if_req    (i_if_req),
    .i_ls_req    (i_ls_req),
    .i_starve_cnt(r_starve_cnt),
    .o_grant_if  (w_grant_if),
    .o_grant_ls  (w_grant_ls),
    .o_contend   (w_contend)
  );

  // Handshakes are gated by reset so nothing is granted or reported while it is held.
  assign w_idle     = (r_state == ST_IDLE) && !i_rst;
  assign o_if_ready = w_idle & w_grant_if;
  assign o_ls_ready = w_idle & w_grant_ls;
  assign w_accept   = o_if_ready | o_ls_ready;
  assign w_sel_addr = o_ls_ready ? i_ls_addr : i_if_addr;

  assign o_mem_req   = (r_state == ST_ISSUE) && !i_rst;
  assign o_mem_wen   = r_wen;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_mask  = r_mask;

  always_comb begin
    w_state_nxt = r_state;
    w_resp      = 1'b0;
    w_err       = 1'b0;
    w_rdata     = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = misaligned(w_sel_addr) ? ST_ERR : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_mem_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_mem_valid) begin
          w_resp      = !i_rst;
          w_rdata     = r_wen ? 32'h0 : i_mem_rdata;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        w_resp      = !i_rst;
        w_err       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_if_valid = w_resp && (r_owner == OWN_IF);
  assign o_ls_valid = w_resp && (r_owner == OWN_LS);
  assign o_if_err   = o_if_valid & w_err;
  assign o_ls_err   = o_ls_valid & w_err;
  assign o_if_rdata = o_if_valid ? w_rdata : 32'h0;
  assign o_ls_rdata = o_ls_valid ? w_rdata : 32'h0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner <= OWN_IF;
      r_wen   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_mask  <= 4'h0;
    end else if (w_accept) begin
      r_owner <= o_ls_ready ? OWN_LS : OWN_IF;
      r_wen   <= o_ls_ready & i_ls_wen;
      r_addr  <= w_sel_addr;
      r_wdata <= o_ls_ready ? i_ls_wdata : 32'h0;
      r_mask  <= o_ls_ready ? i_ls_mask : 4'hF;
    end
  end

  // Counts only rounds fetch actually lost to a competing data request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= 4'h0;
    end else if (o_if_ready) begin
      r_starve_cnt <= 4'h0;
    end else if (o_ls_ready && w_contend && (r_starve_cnt != 4'hF)) begin
      r_starve_cnt <= r_starve_cnt + 4'h1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, starvation and reset
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ready, o_if_valid, o_if_err;
  logic [31:0] o_if_rdata;
  logic        i_ls_req, i_ls_wen;
  logic [31:0] i_ls_addr, i_ls_wdata;
  logic [3:0]  i_ls_mask;
  logic        o_ls_ready, o_ls_valid, o_ls_err;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req, o_mem_wen;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready, i_mem_valid;
  logic [31:0] i_mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_ready(o_if_ready), .o_if_valid(o_if_valid),
    .o_if_rdata(o_if_rdata), .o_if_err(o_if_err),
    .i_ls_req(i_ls_req), .i_ls_wen(i_ls_wen), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_mask(i_ls_mask),
    .o_ls_ready(o_ls_ready), .o_ls_valid(o_ls_valid),
    .o_ls_rdata(o_ls_rdata), .o_ls_err(o_ls_err),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic [1:0]  ls_rw;      // {req, wen}
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_mask;
    logic [1:0]  mem_rv;     // {ready, valid}
    logic [31:0] mem_rdata;
    logic [6:0]  e_flags;    // if_ready ls_ready if_valid if_err ls_valid ls_err mem_req
    logic [31:0] e_if_rdata;
    logic [31:0] e_ls_rdata;
    logic [31:0] e_mem_addr;
    logic        e_mem_wen;
    logic [31:0] e_mem_wdata;
    logic [3:0]  e_mem_mask;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [6:0] flags();
    return {o_if_ready, o_ls_ready, o_if_valid, o_if_err, o_ls_valid, o_ls_err, o_mem_req};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_if_req = 1'b0; i_if_addr = '0;
    i_ls_req = 1'b0; i_ls_wen = 1'b0; i_ls_addr = '0; i_ls_wdata = '0; i_ls_mask = '0;
    i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".flags"}, 32'(flags()), 32'h0);
    chk({tag, ".if_rdata"}, o_if_rdata, 32'h0);
    chk({tag, ".ls_rdata"}, o_ls_rdata, 32'h0);
    chk({tag, ".mem_payload"}, o_mem_addr | o_mem_wdata | 32'(o_mem_mask) | 32'(o_mem_wen), 32'h0);
  endtask

  task automatic apply(input vec_t v, input int k);
    i_if_req    = v.if_req;    i_if_addr  = v.if_addr;
    i_ls_req    = v.ls_rw[1];  i_ls_wen   = v.ls_rw[0];
    i_ls_addr   = v.ls_addr;   i_ls_wdata = v.ls_wdata; i_ls_mask = v.ls_mask;
    i_mem_ready = v.mem_rv[1]; i_mem_valid = v.mem_rv[0]; i_mem_rdata = v.mem_rdata;
    @(negedge i_clk);
    chk($sformatf("row%0d.flags", k), 32'(flags()), 32'(v.e_flags));
    chk($sformatf("row%0d.if_rdata", k), o_if_rdata, v.e_if_rdata);
    chk($sformatf("row%0d.ls_rdata", k), o_ls_rdata, v.e_ls_rdata);
    if (v.e_flags[0]) begin
      chk($sformatf("row%0d.mem_addr", k), o_mem_addr, v.e_mem_addr);
      chk($sformatf("row%0d.mem_wen", k), 32'(o_mem_wen), 32'(v.e_mem_wen));
      chk($sformatf("row%0d.mem_mask", k), 32'(o_mem_mask), 32'(v.e_mem_mask));
      if (v.e_mem_wen) chk($sformatf("row%0d.mem_wdata", k), o_mem_wdata, v.e_mem_wdata);
    end
    next_cycle();
  endtask

  // Randomized-traffic model state: pending requests and the one outstanding transaction.
  bit          if_pend, ls_pend, ls_w;
  logic [31:0] if_a, ls_a, ls_d;
  logic [3:0]  ls_m;
  bit          busy, t_err, t_acc, t_own_ls, t_store;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_mask;
  int          losses;

  initial begin
    int   grants[$];
    int   exp_grants[6];
    bit   g_if, g_ls, resp, e_mreq;
    logic [31:0] e_rd;
    logic [6:0]  e_fl;

    vecs[0]  = '{1'b1, 32'h100, 2'b00, '0, '0, '0, 2'b11, 32'h99, 7'b1000000, '0, '0, '0, 1'b0, '0, '0};
    vecs[1]  = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b10, '0, 7'b0000001, '0, '0, 32'h100, 1'b0, '0, 4'hF};
    vecs[2]  = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b01, 32'hDEADBEEF, 7'b0010000, 32'hDEADBEEF, '0, '0, 1'b0, '0, '0};
    vecs[3]  = '{1'b1, 32'h102, 2'b00, '0, '0, '0, 2'b00, '0, 7'b1000000, '0, '0, '0, 1'b0, '0, '0};
    vecs[4]  = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b10, '0, 7'b0011000, '0, '0, '0, 1'b0, '0, '0};
    vecs[5]  = '{1'b0, '0, 2'b11, 32'h40, 32'hAA, 4'h1, 2'b00, '0, 7'b0100000, '0, '0, '0, 1'b0, '0, '0};
    vecs[6]  = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b01, 32'h5, 7'b0000001, '0, '0, 32'h40, 1'b1, 32'hAA, 4'h1};
    vecs[7]  = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b00, '0, 7'b0000001, '0, '0, 32'h40, 1'b1, 32'hAA, 4'h1};
    vecs[8]  = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b10, '0, 7'b0000001, '0, '0, 32'h40, 1'b1, 32'hAA, 4'h1};
    vecs[9]  = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b01, 32'h12345678, 7'b0000100, '0, '0, '0, 1'b0, '0, '0};
    vecs[10] = '{1'b1, 32'h200, 2'b10, 32'h300, '0, 4'hF, 2'b00, '0, 7'b0100000, '0, '0, '0, 1'b0, '0, '0};
    vecs[11] = '{1'b1, 32'h200, 2'b00, '0, '0, '0, 2'b10, '0, 7'b0000001, '0, '0, 32'h300, 1'b0, '0, 4'hF};
    vecs[12] = '{1'b1, 32'h200, 2'b00, '0, '0, '0, 2'b01, 32'h55, 7'b0000100, '0, 32'h55, '0, 1'b0, '0, '0};
    vecs[13] = '{1'b1, 32'h200, 2'b00, '0, '0, '0, 2'b00, '0, 7'b1000000, '0, '0, '0, 1'b0, '0, '0};
    vecs[14] = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b10, '0, 7'b0000001, '0, '0, 32'h200, 1'b0, '0, 4'hF};
    vecs[15] = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b01, 32'h77, 7'b0010000, 32'h77, '0, '0, 1'b0, '0, '0};
    vecs[16] = '{1'b0, '0, 2'b10, 32'h301, '0, 4'hF, 2'b00, '0, 7'b0100000, '0, '0, '0, 1'b0, '0, '0};
    vecs[17] = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b00, '0, 7'b0000110, '0, '0, '0, 1'b0, '0, '0};
    vecs[18] = '{1'b0, '0, 2'b00, '0, '0, '0, 2'b11, 32'hFFFFFFFF, 7'b0000000, '0, '0, '0, 1'b0, '0, '0};

    idle_inputs();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_all_zero("reset");
    next_cycle();

    for (int k = 0; k < 19; k++) apply(vecs[k], k);

    // Continuous contention: four data grants, then fetch, then data again.
    exp_grants = '{1, 1, 1, 1, 0, 1};
    idle_inputs();
    i_if_req = 1'b1; i_if_addr = 32'h400;
    i_ls_req = 1'b1; i_ls_addr = 32'h500; i_ls_mask = 4'hF;
    i_mem_ready = 1'b1; i_mem_valid = 1'b1; i_mem_rdata = 32'h1234;
    for (int c = 0; c < 100 && grants.size() < 6; c++) begin
      @(negedge i_clk);
      chk("starve.exclusive_ready", 32'(o_if_ready & o_ls_ready), 32'h0);
      if (o_ls_ready) grants.push_back(1);
      else if (o_if_ready) grants.push_back(0);
      next_cycle();
    end
    chk("starve.grant_count", 32'(grants.size()), 32'd6);
    for (int g = 0; g < 6 && g < grants.size(); g++)
      chk($sformatf("starve.grant%0d_is_ls", g), 32'(grants[g]), 32'(exp_grants[g]));

    // Reset while waiting for the memory response.
    idle_inputs();
    i_rst = 1'b1;
    next_cycle(); next_cycle();
    i_rst = 1'b0;
    i_ls_req = 1'b1; i_ls_addr = 32'h600; i_ls_mask = 4'hF;
    @(negedge i_clk);
    chk("rstmid.accept", 32'(o_ls_ready), 32'h1);
    next_cycle();
    i_ls_req = 1'b0; i_mem_ready = 1'b1;
    @(negedge i_clk);
    chk("rstmid.mem_req", 32'(o_mem_req), 32'h1);
    next_cycle();
    i_mem_ready = 1'b0; i_rst = 1'b1;
    @(negedge i_clk);
    chk("rstmid.during_rst", 32'(flags()), 32'h0);
    next_cycle();
    i_rst = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'hBAD0BAD0;
    @(negedge i_clk);
    chk_all_zero("rstmid.stale1");
    next_cycle();
    @(negedge i_clk);
    chk_all_zero("rstmid.stale2");
    next_cycle();
    idle_inputs();

    // Randomized traffic against the transaction-level model.
    if_pend = 0; ls_pend = 0; busy = 0; t_acc = 0; t_err = 0; losses = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!if_pend && $urandom_range(0, 1) == 1) begin
        if_pend = 1;
        if_a = ($urandom & 32'hFFFC) | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      end
      if (!ls_pend && $urandom_range(0, 1) == 1) begin
        ls_pend = 1;
        ls_w = 1'($urandom_range(0, 1));
        ls_d = $urandom;
        ls_m = 4'($urandom_range(1, 15));
        ls_a = ($urandom & 32'hFFFC) | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      end
      i_if_req = if_pend; i_if_addr = if_a;
      i_ls_req = ls_pend; i_ls_wen = ls_w; i_ls_addr = ls_a; i_ls_wdata = ls_d; i_ls_mask = ls_m;
      i_mem_ready = ($urandom_range(0, 3) != 0);
      i_mem_valid = ($urandom_range(0, 2) == 0);
      i_mem_rdata = $urandom;

      g_ls   = !busy && ls_pend && !(if_pend && losses == LIMIT);
      g_if   = !busy && if_pend && !g_ls;
      resp   = busy && (t_err || (t_acc && i_mem_valid));
      e_mreq = busy && !t_err && !t_acc;
      e_rd   = (resp && !t_err && !t_store) ? i_mem_rdata : 32'h0;
      e_fl   = {g_if, g_ls, resp && !t_own_ls, resp && !t_own_ls && t_err,
                resp && t_own_ls, resp && t_own_ls && t_err, e_mreq};

      @(negedge i_clk);
      chk($sformatf("rand%0d.flags", c), 32'(flags()), 32'(e_fl));
      chk($sformatf("rand%0d.if_rdata", c), o_if_rdata, (resp && !t_own_ls) ? e_rd : 32'h0);
      chk($sformatf("rand%0d.ls_rdata", c), o_ls_rdata, (resp && t_own_ls) ? e_rd : 32'h0);
      if (e_mreq) begin
        chk($sformatf("rand%0d.mem_addr", c), o_mem_addr, t_addr);
        chk($sformatf("rand%0d.mem_wen_mask", c), {27'h0, o_mem_wen, o_mem_mask}, {27'h0, t_store, t_mask});
        if (t_store) chk($sformatf("rand%0d.mem_wdata", c), o_mem_wdata, t_wdata);
      end

      if (resp) busy = 0;
      else if (e_mreq && i_mem_ready) t_acc = 1;
      if (g_ls || g_if) begin
        busy     = 1;
        t_acc    = 0;
        t_own_ls = g_ls;
        t_addr   = g_ls ? ls_a : if_a;
        t_store  = g_ls && ls_w;
        t_err    = (t_addr[1:0] != 2'b00);
        t_wdata  = ls_d;
        t_mask   = g_ls ? ls_m : 4'hF;
        if (g_if) losses = 0;
        else if (if_pend) losses = losses + 1;
        if (g_ls) ls_pend = 0;
        else if_pend = 0;
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one backing memory port between the hart's instruction-fetch requester and its load/store requester, replacing the idealised combinational imem/dmem ports with a single handshaked, variable-latency memory. One transaction is outstanding at a time. Data accesses have priority, and a starvation counter bounds how long fetch can be starved. Sits between the hart (fetch and memory stages) and the memory model or cache.

## Interface
- STARVE_LIMIT, 4: consecutive lost arbitrations after which fetch wins over a data request (legal range 1–15).
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_if_req  in  1  fetch request; held with i_if_addr until accepted
- i_if_addr  in  32  fetch byte address
- o_if_ready  out  1  fetch accepted this cycle
- o_if_valid  out  1  one-cycle fetch response
- o_if_rdata  out  32  fetch word; 0 when not valid
- o_if_err  out  1  with o_if_valid: misaligned address, no memory access
- i_ls_req  in  1  data request; held with payload until accepted
- i_ls_wen  in  1  1 = store, 0 = load
- i_ls_addr  in  32  word-aligned data address
- i_ls_wdata  in  32  store data, already lane-shifted
- i_ls_mask  in  4  byte-lane mask
- o_ls_ready  out  1  data request accepted this cycle
- o_ls_valid  out  1  one-cycle data response (loads and stores)
- o_ls_rdata  out  32  load word; 0 for stores and errors
- o_ls_err  out  1  with o_ls_valid: misaligned address
- o_mem_req  out  1  backing request; held until i_mem_ready
- o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask  out  1/32/32/4  latched payload
- i_mem_ready  in  1  backing memory accepts the request
- i_mem_valid  in  1  backing memory response
- i_mem_rdata  in  32  backing read data

## Operation
- FSM states are IDLE, ISSUE, WAIT and ERR. The owner register is IF or LS.
- **IDLE**
  - If either request is pending, pick a winner.
  - LS wins by default. IF wins when only IF requests, or when starve_cnt == STARVE_LIMIT.
  - Assert ready to the winner in the same cycle.
  - Latch the payload and owner. Fetch latches wen=0 and mask=4'b1111.
  - If addr[1:0] != 0, go to ERR; otherwise go to ISSUE.
- **ISSUE**
  - o_mem_req=1 with the latched payload.
  - Move to WAIT on i_mem_ready.
- **WAIT**
  - On i_mem_valid, drive the owner's valid for one cycle (rdata = i_mem_rdata for loads and fetches, 0 for stores), then go to IDLE.
- **ERR**
  - Drive the owner's valid and err for one cycle with rdata 0, then go to IDLE.
  - No memory transaction is issued.
- **Starvation counter (starve_cnt, 4 bits)**
  - Increments when both requesters contend in IDLE and LS wins.
  - Clears when IF wins.
  - Unchanged otherwise.
- ready is asserted only in IDLE, and never to both requesters in the same cycle.
- i_mem_valid outside WAIT, and i_mem_ready outside ISSUE, are ignored.

## Timing
- Accept in cycle T, o_mem_req from T+1. Minimum response at T+2, when i_mem_ready is asserted at T+1 and i_mem_valid at T+2.
- Response valid is combinational from i_mem_valid in WAIT. The next accept is possible in the cycle after the response.
- A misaligned request is accepted at T and its err response is at T+1.
- Throughput is at most one transaction per 3 cycles, or 2 cycles for errors.
- Reset values:
  - state=IDLE, starve_cnt=0, owner=IF, latched payload=0.
  - All outputs 0: ready, valid, err, rdata, o_mem_*.
- Reset mid-transaction drops the outstanding access, and no response is generated for it. A stale i_mem_valid arriving after reset is ignored because the FSM is in IDLE.
- Requesters must keep req and payload stable until they see ready. Changing them before ready is undefined.

## Structure
- Package mem_arb_pkg holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ERR=2'd3);
  - the owner constants (OWN_IF=1'b0, OWN_LS=1'b1).
- Sub-module arb_pick is natural: combinational winner selection from the two requests, starve_cnt and STARVE_LIMIT.
- The FSM, payload latch and response routing stay in the top level.

## Test plan
- **Fetch only:** IF req addr 0x100, memory ready at T+1, valid at T+2 with 0xDEADBEEF.
  - o_if_ready at T; o_if_valid=1, rdata=0xDEADBEEF at T+2; o_ls_valid=0.
- **Contention:** both requesters active in IDLE.
  - o_ls_ready=1, o_if_ready=0; the fetch is served in the next IDLE.
- **Starvation:** LS and IF requesting continuously, STARVE_LIMIT=4.
  - LS wins 4 times, the 5th grant goes to IF, and starve_cnt returns to 0.
- **Misaligned fetch:** IF addr 0x102.
  - o_mem_req stays 0; o_if_valid=1 and o_if_err=1 at T+1.
- **Store with back-pressure:** wdata 0x000000AA, mask 4'b0001; memory ready delayed 3 cycles.
  - o_mem_req stays high for 3 cycles with a stable payload; o_ls_valid=1 with rdata=0.
- **Reset mid-operation:** i_rst asserted in WAIT, then i_mem_valid pulses.
  - No valid is asserted to either requester; state=IDLE and all outputs are 0.
